// File: rtl/hazard_fwd_unit.sv
// RAW-hazard resolution at ID: per-source operand forwarding (EX > MEM > WB),
// load-use stall FSM holding the front end LOAD_LAT cycles, and a saturating stall counter.
module hazard_fwd_unit #(
  parameter int XLEN     = 32,
  parameter int RAW      = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC*RAW-1:0]  id_rs,
  input  logic [NUM_SRC-1:0]      id_src_used,
  input  logic                    ex_we,
  input  logic [RAW-1:0]          ex_rd,
  input  logic                    ex_is_load,
  input  logic [XLEN-1:0]         ex_data,
  input  logic                    mem_we,
  input  logic [RAW-1:0]          mem_rd,
  input  logic [XLEN-1:0]         mem_data,
  input  logic                    wb_we,
  input  logic [RAW-1:0]          wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  input  logic                    flush,
  output logic [NUM_SRC-1:0]      fwd_hit,
  output logic [NUM_SRC*XLEN-1:0] fwd_data,
  output logic                    stall,
  output logic                    bubble,
  output logic [CNT_W-1:0]        stall_cnt
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  localparam logic [3:0]       REM_INIT = 4'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q, state_d;
  logic [3:0]         rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] ex_m, mem_m, wb_m;
  logic               ld_hz;

  always_comb begin
    ex_m     = '0;
    mem_m    = '0;
    wb_m     = '0;
    fwd_hit  = '0;
    fwd_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_m[i]  = id_src_used[i] && ex_we  && (ex_rd  == id_rs[i*RAW +: RAW]) && (ex_rd  != '0);
      mem_m[i] = id_src_used[i] && mem_we && (mem_rd == id_rs[i*RAW +: RAW]) && (mem_rd != '0);
      wb_m[i]  = id_src_used[i] && wb_we  && (wb_rd  == id_rs[i*RAW +: RAW]) && (wb_rd  != '0);
      // A load in EX has no data yet: fall through to older stages, the stall covers it.
      if (ex_m[i] && !ex_is_load) begin
        fwd_hit[i]                 = 1'b1;
        fwd_data[i*XLEN +: XLEN]   = ex_data;
      end else if (mem_m[i]) begin
        fwd_hit[i]                 = 1'b1;
        fwd_data[i*XLEN +: XLEN]   = mem_data;
      end else if (wb_m[i]) begin
        fwd_hit[i]                 = 1'b1;
        fwd_data[i*XLEN +: XLEN]   = wb_data;
      end
    end
  end

  assign ld_hz = ex_is_load && (|ex_m);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (ld_hz && !flush && (LOAD_LAT > 1)) begin
          state_d = WAIT;
          rem_d   = REM_INIT;
        end
      end
      WAIT: begin
        if (flush || (rem_q == 4'd1)) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          rem_d   = rem_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // WAIT holds unconditionally since EX carries our own bubble; only a flush releases it.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    stall = ld_hz && !flush;
        WAIT:    stall = !flush;
        default: stall = 1'b0;
      endcase
    end
  end

  assign bubble = stall;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  assign stall_cnt = cnt_q;

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised RAW-hazard resolution unit for the in-order RISC-V pipeline, placed at the ID stage.
- For each of NUM_SRC decoded source registers it forwards the youngest in-flight result, with priority EX > MEM > WB.
- Detects load-use hazards and holds the front end for a configurable load latency through a small stall FSM.
- Honours branch/jump flushes and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
XLEN, 32, datapath width
RAW, 5, register index width (2^RAW architectural registers; index 0 hardwired zero)
NUM_SRC, 2, number of ID source operands checked (1..4)
LOAD_LAT, 1, front-end stall cycles per load-use hazard (1..15)
CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
id_rs  in  NUM_SRC*RAW  source indices; src i at bits [i*RAW +: RAW]
id_src_used  in  NUM_SRC  bit i=1: instruction actually reads src i
ex_we  in  1  EX instruction writes RF
ex_rd  in  RAW  EX destination
ex_is_load  in  1  EX instruction is a load (result not yet available)
ex_data  in  XLEN  EX result (ALU/immediate, pre-muxed)
mem_we  in  1  MEM writes RF
mem_rd  in  RAW  MEM destination
mem_data  in  XLEN  MEM result (load data or ALU, pre-muxed)
wb_we  in  1  WB writes RF
wb_rd  in  RAW  WB destination
wb_data  in  XLEN  WB write data
flush  in  1  branch/jump redirect; squashes the ID instruction this cycle
fwd_hit  out  NUM_SRC  bit i: fwd_data slot i overrides RF read
fwd_data  out  NUM_SRC*XLEN  forwarded operands, slot i at [i*XLEN +: XLEN]
stall  out  1  hold PC and IF/ID
bubble  out  1  insert NOP into ID/EX (equals stall)
stall_cnt  out  CNT_W  total stalled cycles, saturating

Behaviour:
- Match for src i at stage S: id_src_used[i] & S_we & (S_rd == id_rs[i]) & (S_rd != 0).
- Forwarding is purely combinational; no added latency.
  - EX match with ex_is_load=0: hit=1, data=ex_data.
  - Otherwise MEM match: hit=1, data=mem_data.
  - Otherwise WB match: hit=1, data=wb_data.
  - Otherwise hit=0, data=0.
  - An EX match with ex_is_load=1 does not forward from EX and falls through to the MEM/WB checks. The value it finds there is stale, so the stall below must cover it.
- Load-use detect (ld_hz): any src i with an EX match while ex_is_load=1.
- FSM states: IDLE, WAIT. Counter rem is 4 bits wide.
  - IDLE: stall = ld_hz & ~flush.
    - If stall=1 and LOAD_LAT>1: go to WAIT with rem=LOAD_LAT-1.
    - Otherwise stay in IDLE.
  - WAIT: stall=1 unconditionally, because EX holds a bubble; the FSM does not re-evaluate ld_hz.
    - Each cycle rem decrements.
    - When rem==1, return to IDLE at the next edge.
    - flush=1 in WAIT: stall=0 that cycle, next state IDLE, rem cleared.
- Total stall length per hazard is exactly LOAD_LAT cycles. The load then sits in MEM or WB, and normal forwarding supplies the value.
- With LOAD_LAT=1 the WAIT state is never entered.
- bubble = stall at all times.
- stall_cnt increments on every edge where stall=1 and holds at all-ones.
- Reset (asynchronous, any state including mid-WAIT):
  - state=IDLE, rem=0, stall_cnt=0.
  - stall and bubble are forced 0 while rst=1.
  - fwd outputs remain combinational during reset.
- Simultaneous load-use hazard and flush: flush wins; no stall and no count.
- Multiple sources hitting different stages resolve independently per slot.

Test Plan:
- EX/MEM/WB all write x5 = 0x11/0x22/0x33; id_rs[0]=5, used -> fwd_hit[0]=1, fwd_data slot0=0x11. Deassert ex_we -> 0x22. Deassert mem_we -> 0x33.
- rd=0 in all stages with src=0, or id_src_used=0 with matching rd -> fwd_hit=0, fwd_data=0, stall=0.
- LOAD_LAT=1: ex_is_load=1, ex_rd=7, id_rs[1]=7 used -> stall=bubble=1 for one cycle. Next cycle, with mem_rd=7, mem_data=0xABCD: fwd slot1=0xABCD, stall=0, stall_cnt=1.
- LOAD_LAT=3: same hazard -> stall high for exactly 3 consecutive cycles regardless of EX inputs after cycle 0; stall_cnt=3.
- LOAD_LAT=3 with flush in the 2nd stall cycle -> stall=0 that cycle, FSM back in IDLE, stall_cnt=1. Hazard plus flush in the same IDLE cycle -> no stall.
- Reset asserted mid-WAIT -> stall=0 immediately, stall_cnt=0. CNT_W=4 with 20 stall cycles -> stall_cnt saturates at 15.
